// File: rtl/rst_run_seq.sv
// Reset/run sequencer: pulses NUM_RST active-low resets, releases them staggered,
// then times the run phase against a cycle budget and reports done or timeout.
module rst_run_seq #(
    parameter int unsigned NUM_RST     = 2,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned STAGGER_CYC = 2,
    parameter int unsigned TIMEOUT_CYC = 20,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               done_i,
    output logic [NUM_RST-1:0] rst_no,
    output logic               running_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   run_cnt_o
);

    localparam int unsigned REL_SPAN = (NUM_RST - 1) * STAGGER_CYC;

    // Reject parameter sets whose counters could wrap.
    if (NUM_RST < 1 || PULSE_CYC < 1 || STAGGER_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("rst_run_seq: NUM_RST, PULSE_CYC, STAGGER_CYC and TIMEOUT_CYC must all be >= 1");
    end
    if ((64'(PULSE_CYC) >= (64'd1 << CNT_W)) || (64'(REL_SPAN) >= (64'd1 << CNT_W)) ||
        (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W))) begin : g_bad_width
        $error("rst_run_seq: CNT_W too narrow for configured cycle counts");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ASSERT  = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [NUM_RST-1:0] rst_n_q, rst_n_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [CNT_W-1:0]   run_inc_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            run_cnt_q <= '0;
            rst_n_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_cnt_q <= run_cnt_d;
            rst_n_q   <= rst_n_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        rst_n_d   = rst_n_q;
        running_d = running_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_inc_c = cnt_q + CNT_W'(1);
        run_inc_c = run_cnt_q + CNT_W'(1);

        // A start request restarts the whole sequence from any state.
        if (start_i) begin
            state_d   = S_ASSERT;
            cnt_d     = '0;
            run_cnt_d = '0;
            rst_n_d   = '0;
            running_d = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rst_n_d = '0;
                end
                S_ASSERT: begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(PULSE_CYC)) begin
                        if (NUM_RST == 1) begin
                            state_d   = S_RUN;
                            rst_n_d   = '1;
                            running_d = 1'b1;
                            run_cnt_d = '0;
                        end else begin
                            state_d = S_RELEASE;
                            rst_n_d = NUM_RST'(1);
                            cnt_d   = '0;
                        end
                    end
                end
                S_RELEASE: begin
                    cnt_d = cnt_inc_c;
                    for (int unsigned k = 1; k < NUM_RST; k++) begin
                        if (cnt_inc_c == CNT_W'(k * STAGGER_CYC)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    if (cnt_inc_c == CNT_W'(REL_SPAN)) begin
                        state_d   = S_RUN;
                        running_d = 1'b1;
                        run_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    run_cnt_d = run_inc_c;
                    // Completion beats budget expiry on the same edge.
                    if (done_i) begin
                        state_d   = S_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b0;
                    end else if (run_inc_c == CNT_W'(TIMEOUT_CYC)) begin
                        state_d   = S_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                S_DONE: begin
                    rst_n_d = '1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rst_no    = rst_n_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign run_cnt_o = run_cnt_q;

endmodule

// File: tb/tb_rst_run_seq.sv
// Self-checking bench for rst_run_seq: timeline model checked every cycle plus
// literal expectations at key edges of each directed scenario.
module tb_rst_run_seq;

    localparam int unsigned NUM_RST     = 2;
    localparam int unsigned PULSE_CYC   = 4;
    localparam int unsigned STAGGER_CYC = 2;
    localparam int unsigned TIMEOUT_CYC = 20;
    localparam int unsigned CNT_W       = 16;
    localparam int          RUN_AT      = PULSE_CYC + (NUM_RST - 1) * STAGGER_CYC;

    logic               clk;
    logic               rst;
    logic               start;
    logic               done_in;
    logic [NUM_RST-1:0] rst_n;
    logic               running;
    logic               done_out;
    logic               timeout;
    logic [CNT_W-1:0]   run_cnt;

    int total = 0;
    int bad   = 0;

    rst_run_seq #(
        .NUM_RST    (NUM_RST),
        .PULSE_CYC  (PULSE_CYC),
        .STAGGER_CYC(STAGGER_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .done_i   (done_in),
        .rst_no   (rst_n),
        .running_o(running),
        .done_o   (done_out),
        .timeout_o(timeout),
        .run_cnt_o(run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Timeline model: t counts edges since the start edge E0; end time te is
    // the edge where the run phase finished (done_i or budget).
    bit m_active = 0;
    bit m_ended  = 0;
    bit m_to     = 0;
    int m_t      = 0;
    int m_te     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_ended = 0; m_to = 0; m_t = 0;
        end else if (start) begin
            m_active = 1; m_ended = 0; m_to = 0; m_t = 0;
        end else if (m_active) begin
            if (!m_ended && m_t >= RUN_AT) begin
                if (done_in) begin
                    m_ended = 1; m_te = m_t + 1; m_to = 0;
                end else if (m_t + 1 - RUN_AT == TIMEOUT_CYC) begin
                    m_ended = 1; m_te = m_t + 1; m_to = 1;
                end
            end
            m_t++;
        end
    end

    function automatic logic [NUM_RST-1:0] exp_rstn();
        logic [NUM_RST-1:0] v = '0;
        for (int k = 0; k < NUM_RST; k++)
            v[k] = m_active && (m_t >= PULSE_CYC + k * STAGGER_CYC);
        return v;
    endfunction

    function automatic int exp_runcnt();
        if (!m_active || m_t < RUN_AT) return 0;
        return (m_ended ? m_te : m_t) - RUN_AT;
    endfunction

    always @(negedge clk) begin
        chk("m_rst_no",  32'(rst_n),    32'(exp_rstn()));
        chk("m_running", 32'(running),  32'(m_active && !m_ended && m_t >= RUN_AT));
        chk("m_done",    32'(done_out), 32'(m_active && m_ended));
        chk("m_timeout", 32'(timeout),  32'(m_active && m_ended && m_to));
        chk("m_run_cnt", 32'(run_cnt),  32'(exp_runcnt()));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive start for exactly one edge (E0); returns just after E0.
    task automatic kick();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; done_in = 1'b0;

        // 1: reset dominates start/done toggling
        #1;
        chk("rst_rst_no", 32'(rst_n), 32'h0);
        for (int i = 0; i < 6; i++) begin
            start   = i[0];
            done_in = i[1];
            step(1);
        end
        chk("rst_hold_rst_no", 32'(rst_n), 32'h0);
        chk("rst_hold_run_cnt", 32'(run_cnt), 32'h0);
        start = 1'b0; done_in = 1'b0;
        step(1);
        rst = 1'b0;
        step(3);
        chk("idle_rst_no", 32'(rst_n), 32'h0);

        // 2 + 3: full sequence ending in timeout
        kick();
        chk("s2_e0_rst_no", 32'(rst_n), 32'h0);
        step(3);
        chk("s2_e3_rst_no", 32'(rst_n), 32'h0);
        step(1);
        chk("s2_e4_rst_no", 32'(rst_n), 32'h1);
        step(2);
        chk("s2_e6_rst_no", 32'(rst_n), 32'h3);
        chk("s2_e6_running", 32'(running), 32'h1);
        step(20);
        chk("s3_e26_done", 32'(done_out), 32'h1);
        chk("s3_e26_timeout", 32'(timeout), 32'h1);
        chk("s3_e26_running", 32'(running), 32'h0);
        chk("s3_e26_run_cnt", 32'(run_cnt), 32'd20);
        done_in = 1'b1;
        step(10);
        done_in = 1'b0;
        chk("s3_hold_timeout", 32'(timeout), 32'h1);
        chk("s3_hold_run_cnt", 32'(run_cnt), 32'd20);

        // 4a: done on 5th RUN edge (E11); done_i high during ASSERT is ignored
        done_in = 1'b1;
        kick();
        step(3);
        done_in = 1'b0;
        step(7);
        done_in = 1'b1;
        step(1);
        done_in = 1'b0;
        chk("s4_done", 32'(done_out), 32'h1);
        chk("s4_timeout", 32'(timeout), 32'h0);
        chk("s4_run_cnt", 32'(run_cnt), 32'd5);
        step(4);

        // 4b: done on the budget edge wins
        kick();
        step(25);
        done_in = 1'b1;
        step(1);
        done_in = 1'b0;
        chk("s4b_done", 32'(done_out), 32'h1);
        chk("s4b_timeout", 32'(timeout), 32'h0);
        chk("s4b_run_cnt", 32'(run_cnt), 32'd20);
        step(3);

        // 5: restart during RUN at run_cnt=7
        kick();
        step(13);
        chk("s5_pre_run_cnt", 32'(run_cnt), 32'd7);
        kick();
        chk("s5_rst_no", 32'(rst_n), 32'h0);
        chk("s5_running", 32'(running), 32'h0);
        chk("s5_run_cnt", 32'(run_cnt), 32'h0);
        step(4);
        chk("s5_e4_rst_no", 32'(rst_n), 32'h1);
        step(2);
        chk("s5_e6_rst_no", 32'(rst_n), 32'h3);
        chk("s5_e6_running", 32'(running), 32'h1);
        step(5);

        // 6: async reset mid-RELEASE, no release until a new start
        kick();
        step(4);
        chk("s6_rel_rst_no", 32'(rst_n), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_rst_no", 32'(rst_n), 32'h0);
        step(1);
        rst = 1'b0;
        step(10);
        chk("s6_idle_rst_no", 32'(rst_n), 32'h0);
        chk("s6_idle_running", 32'(running), 32'h0);
        kick();
        step(6);
        chk("s6_restart_rst_no", 32'(rst_n), 32'h3);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
